// File: rtl/lvds_trigger_capture_pkg.sv
// lvds_trigger_capture_pkg: shared constants, state encoding and capture-word packing
package lvds_trigger_capture_pkg;
    localparam int SAMPLES_PER_WORD = 10;
    localparam int SAMPLE_BITS = 12;
    localparam int CLKSTR_BITS = 2;
    localparam int LVDS_WORD_BITS = 140;
    localparam int FIFO_WORD_BITS = 560;
    localparam int SLOT_BITS = SAMPLE_BITS + CLKSTR_BITS;
    localparam logic [7:0] TRIG_IMMEDIATE = 8'd0;
    localparam logic [7:0] TRIG_THRESH = 8'd1;
    typedef enum logic [2:0] {IDLE, WAIT_LOW, WAIT_HIGH, CAPTURE, DONE} state_t;
    typedef logic [SAMPLES_PER_WORD-1:0][SAMPLE_BITS-1:0] samples_t;
    typedef logic [SAMPLES_PER_WORD-1:0][CLKSTR_BITS-1:0] clkstr_t;
    // sample s lands in slot s as {clkstr, sample}; everything above slot 9 is zero
    function automatic logic [FIFO_WORD_BITS-1:0] pack_word(input samples_t smp, input clkstr_t cs);
        logic [FIFO_WORD_BITS-1:0] w;
        w = '0;
        for (int s = 0; s < SAMPLES_PER_WORD; s++) w[s*SLOT_BITS +: SLOT_BITS] = {cs[s], smp[s]};
        return w;
    endfunction
endpackage

// File: rtl/lvds_trigger_capture_word_unpack.sv
// lvds_word_unpack: gathers the bit-interleaved deserializer word into samples and clk/str pairs, one register stage
module lvds_word_unpack
    import lvds_trigger_capture_pkg::*;
(
    input  logic                      clklvds,
    input  logic                      rstn,
    input  logic [LVDS_WORD_BITS-1:0] lvds_bits,
    output samples_t                  samples,
    output clkstr_t                   clkstr
);
    samples_t smp_c;
    clkstr_t  cs_c;
    // bit b of sample s sits at 10*b+s; clk at 120+s, str at 130+s
    always_comb begin
        smp_c = '0;
        cs_c = '0;
        for (int s = 0; s < SAMPLES_PER_WORD; s++) begin
            for (int b = 0; b < SAMPLE_BITS; b++) smp_c[s][b] = lvds_bits[SAMPLES_PER_WORD*b + s];
            cs_c[s] = {lvds_bits[SAMPLES_PER_WORD*SAMPLE_BITS + s], lvds_bits[SAMPLES_PER_WORD*(SAMPLE_BITS+1) + s]};
        end
    end
    // register the unpacked word
    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) begin
            samples <= '0;
            clkstr <= '0;
        end else begin
            samples <= smp_c;
            clkstr <= cs_c;
        end
    end
endmodule

// File: rtl/lvds_trigger_capture.sv
// lvds_trigger_capture: armed LVDS word capture with immediate or low-then-high threshold trigger; LVDS_TEST_PATTERN_EN swaps captured data for a counting pattern
module lvds_trigger_capture
    import lvds_trigger_capture_pkg::*;
(
    input  logic                      clklvds,
    input  logic                      rstn,
    input  logic [LVDS_WORD_BITS-1:0] lvds_bits,
    input  logic                      arm,
    input  logic [7:0]                trig_type,
    input  logic [15:0]               length,
    input  logic [SAMPLE_BITS-1:0]    lower_thresh,
    input  logic [SAMPLE_BITS-1:0]    upper_thresh,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [FIFO_WORD_BITS-1:0] fifo_data,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [15:0]               word_count
);
    logic [2:0] arm_sync;
    logic       arm_s, arm_rise, lo_hit, hi_hit, cap_now, wr_n, ovf_n;
    logic [15:0] count_n;
    samples_t   samples, cap_smp;
    clkstr_t    clkstr, cap_cs;
    state_t     state, state_n;

    lvds_word_unpack u_unpack (
        .clklvds (clklvds),
        .rstn    (rstn),
        .lvds_bits(lvds_bits),
        .samples (samples),
        .clkstr  (clkstr)
    );

    // two-flop arm synchronizer plus one history flop for edge detection
    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) arm_sync <= '0;
        else arm_sync <= {arm_sync[1:0], arm};
    end
    assign arm_s = arm_sync[1];
    assign arm_rise = arm_sync[1] & ~arm_sync[2];
    assign busy = state inside {WAIT_LOW, WAIT_HIGH, CAPTURE};
    assign done = state == DONE;

    // any-sample signed threshold crossings on the live word
    always_comb begin
        lo_hit = 1'b0;
        hi_hit = 1'b0;
        for (int s = 0; s < SAMPLES_PER_WORD; s++) begin
            lo_hit = lo_hit | ($signed(samples[s]) < $signed(lower_thresh));
            hi_hit = hi_hit | ($signed(samples[s]) > $signed(upper_thresh));
        end
    end

`ifdef LVDS_TEST_PATTERN_EN
    // counting pattern indexed by word_count; 16-bit wrap keeps the mod-4096 result exact
    always_comb begin
        cap_smp = '0;
        cap_cs = '0;
        for (int s = 0; s < SAMPLES_PER_WORD; s++) cap_smp[s] = SAMPLE_BITS'(word_count * 16'd10 + 16'(s));
    end
`else
    assign cap_smp = samples;
    assign cap_cs = clkstr;
`endif

    // next state; the word that fires WAIT_HIGH is handled as a capture cycle so it is written first
    always_comb begin
        state_n = state;
        count_n = word_count;
        ovf_n = overflow;
        wr_n = 1'b0;
        cap_now = 1'b0;
        case (state)
            IDLE: begin
                count_n = '0;
                if (arm_rise) begin
                    ovf_n = 1'b0;
                    state_n = (trig_type == TRIG_THRESH) ? WAIT_LOW : CAPTURE;
                end
            end
            WAIT_LOW:  state_n = lo_hit ? WAIT_HIGH : WAIT_LOW;
            WAIT_HIGH: cap_now = hi_hit;
            CAPTURE:   cap_now = 1'b1;
            DONE:      state_n = arm_s ? DONE : IDLE;
            default:   state_n = IDLE;
        endcase
        if (cap_now) begin
            state_n = CAPTURE;
            if (word_count >= length) state_n = DONE;
            else if (fifo_full) begin
                ovf_n = 1'b1;
                state_n = DONE;
            end else begin
                wr_n = 1'b1;
                count_n = word_count + {15'd0, word_count != 16'hFFFF};
            end
        end
        if (busy && !arm_s) begin
            state_n = IDLE;
            wr_n = 1'b0;
            count_n = word_count;
            ovf_n = overflow;
        end
    end

    // state, counters and the registered FIFO write port
    always_ff @(posedge clklvds or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            word_count <= '0;
            overflow <= 1'b0;
            fifo_wr <= 1'b0;
            fifo_data <= '0;
        end else begin
            state <= state_n;
            word_count <= count_n;
            overflow <= ovf_n;
            fifo_wr <= wr_n;
            if (wr_n) fifo_data <= pack_word(cap_smp, cap_cs);
        end
    end
endmodule

// File: tb/tb_lvds_trigger_capture.sv
// tb_lvds_trigger_capture: randomized self-checking bench with a word-level reference for packing, latency and write counts
module tb_lvds_trigger_capture;
    logic         clklvds = 1'b0;
    logic         rstn = 1'b0;
    logic [139:0] lvds_bits = '0;
    logic         arm = 1'b0;
    logic [7:0]   trig_type = 8'd0;
    logic [15:0]  length = 16'd0;
    logic [11:0]  lower_thresh = 12'hFF6;
    logic [11:0]  upper_thresh = 12'd10;
    logic         fifo_full = 1'b0;
    logic         fifo_wr, busy, done, overflow;
    logic [559:0] fifo_data;
    logic [15:0]  word_count;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [559:0] exp_word = '0, w1 = '0, w2 = '0, first_data = '0, last_data = '0, trig_exp;

    lvds_trigger_capture dut (
        .clklvds(clklvds), .rstn(rstn), .lvds_bits(lvds_bits), .arm(arm),
        .trig_type(trig_type), .length(length), .lower_thresh(lower_thresh),
        .upper_thresh(upper_thresh), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
        .fifo_data(fifo_data), .busy(busy), .done(done), .overflow(overflow),
        .word_count(word_count)
    );

    always #5 clklvds = ~clklvds;

    task automatic check(input string tag, input logic [559:0] got, input logic [559:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [559:0] pattern_word(input int k);
        logic [559:0] w;
        w = '0;
        for (int s = 0; s < 10; s++) w[14*s +: 14] = {2'b00, 12'((10*k + s) % 4096)};
        return w;
    endfunction

    // the expected packed form follows the driven word by two clock edges
    always @(posedge clklvds) begin
        w1 <= exp_word;
        w2 <= w1;
    end

    // every write is checked against the reference word and counted
    always @(negedge clklvds) begin
        if (rstn && fifo_wr) begin
`ifdef LVDS_TEST_PATTERN_EN
            check("write_data", fifo_data, pattern_word(wr_cnt));
`else
            check("write_data", fifo_data, w2);
`endif
            if (wr_cnt == 0) first_data = fifo_data;
            last_data = fifo_data;
            wr_cnt++;
        end
    end

    task automatic send(input logic [9:0][11:0] smp, input logic [9:0][1:0] cs);
        @(negedge clklvds);
        #1;
        exp_word = '0;
        for (int s = 0; s < 10; s++) begin
            for (int b = 0; b < 12; b++) lvds_bits[10*b + s] = smp[s][b];
            lvds_bits[120 + s] = cs[s][1];
            lvds_bits[130 + s] = cs[s][0];
            exp_word[14*s +: 14] = {cs[s], smp[s]};
        end
    endtask

    // mode 0: any value; mode 1: within [-10, +10] so no threshold fires
    task automatic send_rand(input int mode);
        logic [9:0][11:0] smp;
        logic [9:0][1:0]  cs;
        for (int s = 0; s < 10; s++) begin
            smp[s] = (mode == 0) ? 12'($urandom) : 12'($urandom_range(20)) - 12'd10;
            cs[s] = 2'($urandom);
        end
        send(smp, cs);
    endtask

    task automatic idle(input int n, input int mode);
        repeat (n) send_rand(mode);
    endtask

    task automatic send_one(input int idx, input logic [11:0] val);
        logic [9:0][11:0] smp;
        logic [9:0][1:0]  cs;
        smp = '0;
        cs = '0;
        smp[idx] = val;
        send(smp, cs);
    endtask

    initial begin
        logic [9:0][11:0] smp;
        logic [9:0][1:0]  cs;
        int len, snap;
        #12;
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_word_count", word_count, 0);
        check("rst_fifo_data", fifo_data, 0);
        rstn = 1'b1;
        idle(3, 0);

        trig_type = 8'd0;
        length = 16'd5;
        wr_cnt = 0;
        arm = 1'b1;
        idle(20, 0);
        check("imm_writes", wr_cnt, 5);
        check("imm_word_count", word_count, 5);
        check("imm_done", done, 1);
        check("imm_overflow", overflow, 0);
        check("imm_busy", busy, 0);
        arm = 1'b0;
        idle(5, 0);
        check("imm_done_clr", done, 0);
        check("imm_count_clr", word_count, 0);

        for (int i = 0; i < 6; i++) begin
            trig_type = (i % 2 == 1) ? 8'($urandom_range(255, 2)) : 8'd0;
            len = $urandom_range(8);
            length = 16'(len);
            wr_cnt = 0;
            arm = 1'b1;
            idle(len + 8, 0);
            check("rnd_writes", wr_cnt, len);
            check("rnd_word_count", word_count, len);
            check("rnd_done", done, 1);
            arm = 1'b0;
            idle(5, 0);
            check("rnd_idle", {busy, done}, 0);
        end

        trig_type = 8'd1;
        length = 16'd3;
        wr_cnt = 0;
        arm = 1'b1;
        idle(5, 1);
        check("thr_wait_busy", busy, 1);
        send_one($urandom_range(9), 12'd20);
        idle(3, 1);
        check("thr_high_first_ignored", wr_cnt, 0);
        send_one($urandom_range(9), 12'hFEC);
        smp = '0;
        cs = '0;
        smp[2] = 12'hFF6;
        smp[5] = 12'd10;
        send(smp, cs);
        idle(3, 1);
        check("thr_boundary_no_write", wr_cnt, 0);
        send_one(7, 12'd20);
        trig_exp = exp_word;
        idle(10, 1);
        check("thr_writes", wr_cnt, 3);
`ifdef LVDS_TEST_PATTERN_EN
        check("thr_first_word", first_data, pattern_word(0));
`else
        check("thr_first_word", first_data, trig_exp);
`endif
        check("thr_done", done, 1);
        arm = 1'b0;
        idle(5, 1);

        trig_type = 8'd0;
        length = 16'd100;
        wr_cnt = 0;
        arm = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (wr_cnt == 3) fifo_full = 1'b1;
            send_rand(0);
        end
        check("ovf_writes", wr_cnt, 3);
        check("ovf_flag", overflow, 1);
        check("ovf_done", done, 1);
        check("ovf_word_count", word_count, 3);
        fifo_full = 1'b0;
        arm = 1'b0;
        idle(5, 0);
        check("ovf_sticky", overflow, 1);
        length = 16'd2;
        wr_cnt = 0;
        arm = 1'b1;
        idle(10, 0);
        check("ovf_cleared_on_arm", overflow, 0);
        check("ovf_rearm_writes", wr_cnt, 2);
        arm = 1'b0;
        idle(5, 0);

        trig_type = 8'd1;
        length = 16'd4;
        wr_cnt = 0;
        arm = 1'b1;
        idle(5, 1);
        send_one(0, 12'hF00);
        idle(3, 1);
        check("abort_busy_before", busy, 1);
        arm = 1'b0;
        idle(6, 1);
        send_one(4, 12'd300);
        idle(6, 1);
        check("abort_writes", wr_cnt, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);

        trig_type = 8'd0;
        length = 16'd1000;
        wr_cnt = 0;
        arm = 1'b1;
        idle(10, 0);
        snap = wr_cnt;
        arm = 1'b0;
        idle(5, 0);
        check("abort_cap_tail_ok", (wr_cnt - snap) <= 3, 1);
        snap = wr_cnt;
        idle(10, 0);
        check("abort_cap_stopped", wr_cnt, snap);
        check("abort_cap_busy", busy, 0);

        length = 16'd50;
        arm = 1'b1;
        idle(8, 0);
        @(posedge clklvds);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_fifo_wr", fifo_wr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_word_count", word_count, 0);
        check("midrst_fifo_data", fifo_data, 0);
        arm = 1'b0;
        idle(3, 0);
        rstn = 1'b1;
        idle(3, 0);

`ifdef LVDS_TEST_PATTERN_EN
        length = 16'd2;
        wr_cnt = 0;
        arm = 1'b1;
        idle(12, 0);
        check("pat_writes", wr_cnt, 2);
        check("pat_w1_s3", last_data[55:42], 14'h000D);
`else
        length = 16'd1;
        wr_cnt = 0;
        for (int s = 0; s < 10; s++) begin
            smp[s] = 12'h100 + 12'(s);
            cs[s] = 2'b10;
        end
        arm = 1'b1;
        repeat (12) send(smp, cs);
        check("pack_writes", wr_cnt, 1);
        check("pack_s0", first_data[13:0], 14'h2100);
        check("pack_s9", first_data[139:126], 14'h2109);
        check("pack_msbs", first_data[559:140], 0);
`endif
        arm = 1'b0;
        idle(4, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
